// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control sequencer for the multi-cycle MIPS datapath. Walks each
//   instruction through FETCH/DECODE/EXEC/MEM/WB, decoding op/func from the
//   IR, and drives every datapath enable and mux select. Memory accesses wait
//   on mem_ready, with an optional timeout that raises a sticky bus error.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   op, func   in   instruction[31:26] and instruction[5:0] from the IR
//   zero       in   ALU zero flag (beq condition)
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access request (FETCH / MEM)
//   memwrite   out  store strobe, qualified by mem_req
//   irwrite    out  load IR
//   pcwrite    out  update PC
//   pcsrc      out  next PC: 00 pc+4, 01 branch, 10 jump, 11 rs
//   regwrite   out  GPR write enable
//   regdst     out  destination: 00 rt, 01 rd, 10 $31
//   memtoreg   out  writeback data: 00 ALUOut, 01 MDR, 10 PC
//   alusrc     out  ALU B: 0 register, 1 extended immediate
//   aluop      out  00 add, 01 sub, 10 or, 11 pass-B
//   extop      out  00 zero, 01 sign, 10 lui
//   illegal    out  sticky: undecodable instruction seen
//   bus_err    out  sticky: memory timeout seen
//   state      out  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrc,
    output logic [1:0] aluop,
    output logic [1:0] extop,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             illegal_reg, illegal_next;
    logic             bus_err_reg, bus_err_next;
    logic             timeout;

    // Instruction decode; the IR is stable for the whole instruction.
    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

    assign is_rtype = (op == OP_RTYPE);
    assign is_addu  = is_rtype && (func == FN_ADDU);
    assign is_subu  = is_rtype && (func == FN_SUBU);
    assign is_jr    = is_rtype && (func == FN_JR);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j | is_jal;

    // The counter holds the number of cycles already spent waiting, so the
    // access is abandoned on the cycle after MEM_TIMEOUT unanswered cycles.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign timeout = ((state_reg == S_FETCH) || (state_reg == S_MEM)) &&
                             !mem_ready && (cnt_reg == CNT_W'(MEM_TIMEOUT));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_FETCH;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            illegal_reg <= illegal_next;
            bus_err_reg <= bus_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = '0;
        illegal_next = illegal_reg;
        bus_err_next = bus_err_reg;
        mem_req      = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        pcsrc        = 2'b00;
        regwrite     = 1'b0;
        regdst       = 2'b00;
        memtoreg     = 2'b00;
        alusrc       = 1'b0;
        aluop        = 2'b00;
        extop        = 2'b00;

        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    // Retry the fetch with a fresh wait budget.
                    bus_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DECODE: begin
                state_next = S_FETCH;
                if (!is_legal) begin
                    illegal_next = 1'b1;
                end else if (is_j) begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end else if (is_jal) begin
                    // PC was already advanced in FETCH, so it holds pc+4.
                    pcwrite  = 1'b1;
                    pcsrc    = 2'b10;
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                end else if (is_jr) begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b11;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_FETCH;
                if (is_addu || is_subu) begin
                    aluop      = is_subu ? 2'b01 : 2'b00;
                    state_next = S_WB;
                end else if (is_ori) begin
                    alusrc     = 1'b1;
                    aluop      = 2'b10;
                    state_next = S_WB;
                end else if (is_lui) begin
                    alusrc     = 1'b1;
                    extop      = 2'b10;
                    aluop      = 2'b11;
                    state_next = S_WB;
                end else if (is_lw || is_sw) begin
                    alusrc     = 1'b1;
                    extop      = 2'b01;
                    state_next = S_MEM;
                end else if (is_beq) begin
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    pcwrite = zero;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                // Withdraw the store strobe on the cycle the access is abandoned.
                memwrite = is_sw && !timeout;
                if (mem_ready) begin
                    state_next = is_sw ? S_FETCH : S_WB;
                end else if (timeout) begin
                    bus_err_next = 1'b1;
                    state_next   = S_FETCH;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_WB: begin
                regwrite   = 1'b1;
                regdst     = is_rtype ? 2'b01 : 2'b00;
                memtoreg   = is_lw ? 2'b01 : 2'b00;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Enables must fall the moment reset_n drops, not at the next edge.
        if (!reset_n) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            pcsrc    = 2'b00;
            regwrite = 1'b0;
            regdst   = 2'b00;
            memtoreg = 2'b00;
            alusrc   = 1'b0;
            aluop    = 2'b00;
            extop    = 2'b00;
        end
    end

    assign illegal = illegal_reg;
    assign bus_err = bus_err_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Drives instructions through multicycle_ctrl (MEM_TIMEOUT=4) and compares
//   every cycle against an instruction-level reference: each instruction is
//   described by its class and its datapath settings, and the expected
//   outputs per phase follow from that description.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BR  = 3;
    localparam int K_JMP = 4;
    localparam int K_ILL = 5;

    typedef struct packed {
        logic [2:0] kind;
        logic [1:0] aluop;
        logic       alusrc;
        logic [1:0] extop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] jpc;
        logic       jal;
    } desc_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, irwrite, pcwrite, regwrite, alusrc;
    logic [1:0] pcsrc, regdst, memtoreg, aluop, extop;
    logic       illegal, bus_err;
    logic [2:0] state;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrc(alusrc), .aluop(aluop), .extop(extop),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {mem_req, memwrite, irwrite, pcwrite, pcsrc, regwrite,
                       regdst, memtoreg, alusrc, aluop, extop};

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0..4 = FETCH..WB.
    int    m_phase = 0;
    int    m_waits = 0;
    bit    m_ill = 0;
    bit    m_bus = 0;
    desc_t m_d;

    function automatic desc_t mk(int kind, logic [1:0] alu, logic src, logic [1:0] ext,
                                 logic [1:0] rd, logic [1:0] mtr, logic [1:0] jpc, logic jal);
        desc_t d;
        d.kind = 3'(kind); d.aluop = alu; d.alusrc = src; d.extop = ext;
        d.regdst = rd; d.memtoreg = mtr; d.jpc = jpc; d.jal = jal;
        return d;
    endfunction

    function automatic desc_t describe(logic [5:0] o, logic [5:0] f);
        case (o)
            6'b000000: case (f)
                6'b100001: return mk(K_ALU, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0);
                6'b100011: return mk(K_ALU, 2'b01, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0);
                6'b001000: return mk(K_JMP, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b11, 0);
                default:   return mk(K_ILL, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            endcase
            6'b001101: return mk(K_ALU, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            6'b001111: return mk(K_ALU, 2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0);
            6'b100011: return mk(K_LD,  2'b00, 1, 2'b01, 2'b00, 2'b01, 2'b00, 0);
            6'b101011: return mk(K_ST,  2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
            6'b000100: return mk(K_BR,  2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            6'b000010: return mk(K_JMP, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b10, 0);
            6'b000011: return mk(K_JMP, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b10, 1);
            default:   return mk(K_ILL, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        endcase
    endfunction

    // Zero-wait cycle count for each instruction class.
    function automatic int exp_cycles(int kind);
        case (kind)
            K_LD:    return 5;
            K_ST:    return 4;
            K_ALU:   return 4;
            K_BR:    return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(int ph, desc_t d, logic z, logic rdy, logic to);
        logic       mreq, mw, irw, pcw, rw, als;
        logic [1:0] pcs, rd, mtr, alu, ext;
        mreq = 0; mw = 0; irw = 0; pcw = 0; rw = 0; als = 0;
        pcs = 0; rd = 0; mtr = 0; alu = 0; ext = 0;
        case (ph)
            0: begin mreq = 1; if (rdy) begin irw = 1; pcw = 1; end end
            1: if (d.kind == 3'(K_JMP)) begin
                   pcw = 1; pcs = d.jpc;
                   if (d.jal) begin rw = 1; rd = 2'b10; mtr = 2'b10; end
               end
            2: begin
                   als = d.alusrc; alu = d.aluop; ext = d.extop;
                   if (d.kind == 3'(K_BR)) begin pcs = 2'b01; pcw = z; end
               end
            3: begin mreq = 1; mw = (d.kind == 3'(K_ST)) && !to; end
            4: begin rw = 1; rd = d.regdst; mtr = d.memtoreg; end
            default: ;
        endcase
        return {mreq, mw, irw, pcw, pcs, rw, rd, mtr, als, alu, ext};
    endfunction

    // One clock: compare at the falling edge, then advance the model.
    task automatic step();
        logic       to;
        logic [15:0] e;
        int         nxt;
        @(negedge clk);
        to = ((m_phase == 0) || (m_phase == 3)) && !mem_ready && (m_waits == TO);
        e = exp_out(m_phase, m_d, zero, mem_ready, to);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL outputs phase=%0d op=%b func=%b observed=%h expected=%h",
                   m_phase, op, func, obs, e);
        end
        checks++;
        assert (state === 3'(m_phase)) else begin
            errors++;
            $error("FAIL state observed=%0d expected=%0d", state, m_phase);
        end
        checks++;
        assert ({illegal, bus_err} === {m_ill, m_bus}) else begin
            errors++;
            $error("FAIL flags observed=%b%b expected=%b%b", illegal, bus_err, m_ill, m_bus);
        end
        nxt = m_phase;
        case (m_phase)
            0: if (mem_ready) nxt = 1; else if (to) m_bus = 1;
            1: if (m_d.kind == 3'(K_JMP)) nxt = 0;
               else if (m_d.kind == 3'(K_ILL)) begin m_ill = 1; nxt = 0; end
               else nxt = 2;
            2: if (m_d.kind == 3'(K_ALU)) nxt = 4;
               else if (m_d.kind == 3'(K_BR)) nxt = 0;
               else nxt = 3;
            3: if (mem_ready) nxt = (m_d.kind == 3'(K_ST)) ? 0 : 4;
               else if (to) begin m_bus = 1; nxt = 0; end
            default: nxt = 0;
        endcase
        if (((m_phase == 0) || (m_phase == 3)) && !mem_ready && !to) m_waits++;
        else m_waits = 0;
        m_phase = nxt;
        @(posedge clk);
        #1;
    endtask

    // fw/mw: cycles of mem_ready=0 before the fetch / memory access answers.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw, output int ncyc);
        int fleft, mleft, ph, guard;
        bit started;
        op = o; func = f; zero = z;
        m_d = describe(o, f);
        fleft = fw; mleft = mw; ncyc = 0; guard = 0; started = 0;
        do begin
            ph = m_phase;
            if (ph == 0)      mem_ready = (fleft == 0);
            else if (ph == 3) mem_ready = (mleft == 0);
            else              mem_ready = 1'($urandom_range(0, 1));
            step();
            if (ph == 0 && fleft > 0) fleft--;
            if (ph == 3 && mleft > 0) mleft--;
            if (m_phase != 0) started = 1;
            ncyc++;
            guard++;
        end while (!(started && m_phase == 0) && guard < 60);
        if (guard >= 60) begin
            checks++;
            assert (guard < 60) else begin
                errors++;
                $error("FAIL instr_budget op=%b observed=%0d cycles required<60", o, guard);
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        checks++;
        assert ({obs, state, illegal, bus_err} === 21'd0) else begin
            errors++;
            $error("FAIL %s observed=%h/%0d/%b%b required=0", tag, obs, state, illegal, bus_err);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        reset_checks("reset_state");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_phase = 0; m_waits = 0; m_ill = 0; m_bus = 0;
    endtask

    logic [5:0] ops [10]   = '{6'h00, 6'h00, 6'h00, 6'b001101, 6'b001111, 6'b100011,
                               6'b101011, 6'b000100, 6'b000010, 6'b000011};
    logic [5:0] funcs [10] = '{6'b100001, 6'b100011, 6'b001000, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        int n;
        do_reset();

        // lw zero-wait: F D E M W
        run_instr(6'b100011, 6'h00, 0, 0, 0, n);
        checks++;
        assert (n === 5) else begin errors++; $error("FAIL lw_cycles observed=%0d required=5", n); end

        // beq taken then not taken
        run_instr(6'b000100, 6'h00, 1, 0, 0, n);
        checks++;
        assert (n === 3) else begin errors++; $error("FAIL beq1_cycles observed=%0d required=3", n); end
        run_instr(6'b000100, 6'h00, 0, 0, 0, n);
        checks++;
        assert (n === 3) else begin errors++; $error("FAIL beq0_cycles observed=%0d required=3", n); end

        // jal
        run_instr(6'b000011, 6'h00, 0, 0, 0, n);
        checks++;
        assert (n === 2) else begin errors++; $error("FAIL jal_cycles observed=%0d required=2", n); end

        // sw with three unanswered MEM cycles
        run_instr(6'b101011, 6'h00, 0, 0, 3, n);
        checks++;
        assert (n === 7) else begin errors++; $error("FAIL sw_wait_cycles observed=%0d required=7", n); end

        // every supported instruction, zero-wait
        for (int i = 0; i < 10; i++) begin
            run_instr(ops[i], funcs[i], 1'($urandom_range(0, 1)), 0, 0, n);
            checks++;
            assert (n === exp_cycles(int'(describe(ops[i], funcs[i]).kind))) else begin
                errors++;
                $error("FAIL cycles op=%b func=%b observed=%0d required=%0d", ops[i], funcs[i], n,
                       exp_cycles(int'(describe(ops[i], funcs[i]).kind)));
            end
        end

        // illegal R-type func, then reset in the EXEC of an addu
        run_instr(6'h00, 6'b111111, 0, 0, 0, n);
        checks++;
        assert (illegal === 1'b1 && n === 2) else begin
            errors++;
            $error("FAIL illegal observed=%b/%0d required=1/2", illegal, n);
        end
        op = 6'h00; func = 6'b100001; m_d = describe(op, func);
        mem_ready = 1'b1; step();
        mem_ready = 1'b0; step();
        #2 reset_n = 1'b0;
        #1;
        reset_checks("reset_mid_exec");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_phase = 0; m_waits = 0; m_ill = 0; m_bus = 0;

        // randomized instruction stream with occasional long waits
        for (int i = 0; i < 150; i++) begin
            int k, fw, mw;
            logic [5:0] o, f;
            k = $urandom_range(0, 11);
            if (k < 10) begin o = ops[k]; f = funcs[k]; end
            else if (k == 10) begin o = 6'($urandom_range(16, 63)); f = 6'($urandom); end
            else begin o = 6'h00; f = 6'b000000; end
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 7);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 7);
            run_instr(o, f, 1'($urandom_range(0, 1)), fw, mw, n);
        end

        // fetch timeout: mem_ready stuck low
        do_reset();
        run_instr(6'b100011, 6'h00, 0, 6, 0, n);
        checks++;
        assert (bus_err === 1'b1) else begin
            errors++; $error("FAIL bus_err_set observed=%b required=1", bus_err);
        end
        run_instr(6'b001101, 6'h00, 0, 0, 0, n);
        checks++;
        assert (bus_err === 1'b1) else begin
            errors++; $error("FAIL bus_err_sticky observed=%b required=1", bus_err);
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle control decoder, for the multi-cycle MIPS datapath.
- Decodes op/func once per instruction.
- Sequences FETCH/DECODE/EXEC/MEM/WB, waiting on a memory ready handshake with an optional timeout.
- Drives every datapath enable and mux select, including new jal/jr/lui paths and an illegal-instruction flag.

Parameters:
- MEM_TIMEOUT, default 0: maximum cycles spent waiting on mem_ready in one memory access. 0 = wait forever.
- CNT_W, default 8: width of the wait counter. Must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  6  instruction[31:26], taken from the IR.
- func  in  6  instruction[5:0], taken from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- memwrite  out  1  store strobe, valid while mem_req=1.
- irwrite  out  1  load IR.
- pcwrite  out  1  update PC.
- pcsrc  out  2  next PC select: 00 pc+4, 01 branch target, 10 jump target, 11 rs.
- regwrite  out  1  GPR write enable.
- regdst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- memtoreg  out  2  writeback data: 00 ALUOut, 01 MDR, 10 PC.
- alusrc  out  1  ALU B input: 0 register, 1 extended immediate.
- aluop  out  2  ALU operation: 00 add, 01 sub, 10 or, 11 pass-B.
- extop  out  2  immediate extension: 00 zero, 01 sign, 10 lui (imm<<16).
- illegal  out  1  sticky flag: undecodable instruction seen.
- bus_err  out  1  sticky flag: memory timeout.
- state  out  3  current state, for debug.

Behaviour:
- Supported instructions:
  - R-type op 000000 with func addu 100001, subu 100011, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Reset, asynchronous: state=FETCH, wait counter=0, illegal=0, bus_err=0.
- All control outputs are Moore or Mealy combinational from state/op/func/mem_ready. Each defaults to 0 in any state not listed below.
- FETCH:
  - mem_req=1.
  - When mem_ready=1: irwrite=1, pcwrite=1, pcsrc=00, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - j: pcwrite=1, pcsrc=10, go to FETCH.
  - jal: pcwrite=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10 (PC already holds pc+4), go to FETCH.
  - jr: pcwrite=1, pcsrc=11, go to FETCH.
  - Illegal op or func: set illegal, go to FETCH. The instruction is a no-op.
  - Otherwise go to EXEC.
- EXEC:
  - addu/subu: alusrc=0, aluop=00/01, go to WB.
  - ori: alusrc=1, extop=00, aluop=10, go to WB.
  - lui: alusrc=1, extop=10, aluop=11, go to WB.
  - lw/sw: alusrc=1, extop=01, aluop=00, go to MEM.
  - beq: alusrc=0, aluop=01, pcsrc=01, pcwrite=zero, go to FETCH.
- MEM:
  - mem_req=1; memwrite=1 for sw.
  - When mem_ready=1: sw goes to FETCH, lw goes to WB.
- WB:
  - regwrite=1, then go to FETCH.
  - R-type: regdst=01, memtoreg=00.
  - ori/lui: regdst=00, memtoreg=00.
  - lw: regdst=00, memtoreg=01.
- Wait counter:
  - Cleared on entering FETCH or MEM.
  - Increments each cycle in FETCH/MEM with mem_req=1 and mem_ready=0.
- Timeout, only when MEM_TIMEOUT>0: when the counter reaches MEM_TIMEOUT with mem_ready still 0:
  - Set bus_err and abort to FETCH (MEM) or retry FETCH.
  - No irwrite, pcwrite, memwrite or regwrite effect in that cycle.
- mem_ready outside FETCH/MEM is ignored.
- Flags: illegal and bus_err are cleared only by reset.
- Reset mid-instruction: all enables drop immediately (asynchronous); no partial write completes after reset_n falls.
- Cycle counts with zero-wait memory:
  - j/jal/jr: 2 cycles.
  - beq/sw: 3 cycles (sw takes 4 including MEM). Exact counts: beq 3, sw 4.
  - R-type/ori/lui: 4 cycles.
  - lw: 5 cycles.

Test Plan:
1. Reset, then op=100011, mem_ready=1 always -> state sequence 0,1,2,3,4,0. In WB: regwrite=1, regdst=00, memtoreg=01. In EXEC: extop=01, alusrc=1, aluop=00.
2. op=000100 with zero=1, then again with zero=0 -> EXEC pcsrc=01 in both cases; pcwrite=1 then 0; no regwrite in either case; back in FETCH after 3 cycles.
3. op=000011 -> in DECODE: pcwrite=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10; next state FETCH.
4. op=101011, mem_ready held 0 for 3 MEM cycles then 1 -> mem_req=1 and memwrite=1 for 4 MEM cycles, then FETCH; regwrite never asserted.
5. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err=1 after 4 waiting cycles; irwrite and pcwrite stay 0; bus_err stays 1 until reset_n=0.
6. op=000000, func=111111 -> illegal=1 after DECODE, return to FETCH with no write enables; assert reset_n=0 mid-EXEC of a following addu -> state=0 and all outputs 0 asynchronously.
